sprite_gfx_server: RTL and testbench

Graphics-memory responder for the hardware sprite engine. It owns the shared single-port sprite bitmap RAM and serves line reads to `NUM_SPRITES` sprite instances through a round-robin, time-slotted `dma_avail` grant. Each read returns the requested line one clock later on a shared `data` bus. A loader-side write port fills the RAM, and per-sprite base-address registers select which bitmap each sprite draws. It sits between the sprite instances and the bridge or loader logic in the video pipeline.

---
 rtl/sprite_gfx_server.sv | 81 ++++++++
 tb/tb_sprite_gfx_server.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_gfx_server.sv
// Sprite bitmap RAM responder: round-robin time-slotted line reads for NUM_SPRITES
// clients, a loader write port, and per-sprite base-address registers.
module sprite_base_reg #(
  parameter int AW = 11
) (
  input  logic          pixel_clock,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] q
);
  always_ff @(posedge pixel_clock)
    if (!reset_n) q <= '0;
    else if (we)  q <= din;
endmodule

module sprite_gfx_server #(
  parameter int NUM_SPRITES    = 4,
  parameter int WIDTH          = 8,
  parameter int ADDR_WIDTH     = 9,
  parameter int MEM_ADDR_WIDTH = 11,
  localparam int SEL_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                              pixel_clock,
  input  logic                              reset_n,
  input  logic                              dma_window,
  input  logic [NUM_SPRITES*ADDR_WIDTH-1:0] pos_bus,
  input  logic                              base_we,
  input  logic [SEL_W-1:0]                  base_sel,
  input  logic [MEM_ADDR_WIDTH-1:0]         base_addr,
  input  logic                              wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0]         wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
  output logic [NUM_SPRITES-1:0]            dma_avail,
  output logic [WIDTH-1:0]                  data
);
  localparam int SUM_W = (ADDR_WIDTH > MEM_ADDR_WIDTH) ? ADDR_WIDTH : MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [NUM_SPRITES-1:0][ADDR_WIDTH-1:0]     pos;
  logic [NUM_SPRITES-1:0][MEM_ADDR_WIDTH-1:0] base;
  logic [SEL_W-1:0]                           slot;
  logic                                       grant;
  logic [SUM_W-1:0]                           rd_sum;
  logic [MEM_ADDR_WIDTH-1:0]                  rd_addr;
  logic [WIDTH-1:0]                           mem [DEPTH];

  assign pos   = pos_bus;
  // Loader writes win the single RAM port; reset also masks the grant.
  assign grant = reset_n & dma_window & ~wr_en;

  // Sum wraps modulo RAM depth by truncation.
  assign rd_sum  = SUM_W'(base[slot]) + SUM_W'(pos[slot]);
  assign rd_addr = rd_sum[MEM_ADDR_WIDTH-1:0];

  genvar k;
  generate
    for (k = 0; k < NUM_SPRITES; k++) begin : g_client
      assign dma_avail[k] = grant & (slot == SEL_W'(k));
      sprite_base_reg #(.AW(MEM_ADDR_WIDTH)) u_base (
        .pixel_clock (pixel_clock),
        .reset_n     (reset_n),
        .we          (base_we & (base_sel == SEL_W'(k))),
        .din         (base_addr),
        .q           (base[k])
      );
    end
  endgenerate

  always_ff @(posedge pixel_clock)
    if (wr_en) mem[wr_addr] <= wr_data;

  always_ff @(posedge pixel_clock)
    if (!reset_n) begin
      slot <= '0;
      data <= '0;
    end else if (grant) begin
      data <= mem[rd_addr];
      slot <= (slot == SEL_W'(NUM_SPRITES-1)) ? '0 : slot + SEL_W'(1);
    end
endmodule

// File: tb/tb_sprite_gfx_server.sv
// Scoreboard bench for sprite_gfx_server: directed scenarios plus randomized traffic
// checked against a cycle-level reference of slots, bases and RAM contents.
module tb_sprite_gfx_server;
  localparam int N = 4, W = 8, AW = 9, MAW = 11, SW = 2, DEPTH = 2048;

  logic              pixel_clock = 1'b0;
  logic              reset_n, dma_window, base_we, wr_en;
  logic [SW-1:0]     base_sel;
  logic [MAW-1:0]    base_addr, wr_addr;
  logic [W-1:0]      wr_data;
  logic [N*AW-1:0]   pos_bus;
  logic [N-1:0]      dma_avail;
  logic [W-1:0]      data;

  sprite_gfx_server #(.NUM_SPRITES(N), .WIDTH(W), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MAW)) dut (
    .pixel_clock (pixel_clock),
    .reset_n     (reset_n),
    .dma_window  (dma_window),
    .pos_bus     (pos_bus),
    .base_we     (base_we),
    .base_sel    (base_sel),
    .base_addr   (base_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .dma_avail   (dma_avail),
    .data        (data)
  );

  always #5 pixel_clock = ~pixel_clock;

  int checks = 0, passes = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
  endtask

  task automatic step();
    @(posedge pixel_clock);
    #1;
  endtask

  // Reference model: a line request returns RAM[(base+pos) mod depth] one cycle later.
  logic [W-1:0] ref_mem [DEPTH];
  int           ref_base [N];
  int           ref_slot = 0;
  logic [W-1:0] exp_q [$];
  bit           pend = 0, rst_seen = 0;
  logic [W-1:0] last_d = '0;

  always @(negedge pixel_clock) begin
    int p, a;
    bit g;
    if (rst_seen) begin
      if (pend) begin
        last_d = exp_q.pop_front();
        chk("sb_data", data, last_d);
      end else chk("sb_hold", data, last_d);
    end
    g = reset_n && dma_window && !wr_en;
    chk("sb_grant", dma_avail, g ? (32'd1 << ref_slot) : 32'd0);
    pend = 0;
    if (!reset_n) begin
      ref_slot = 0;
      foreach (ref_base[i]) ref_base[i] = 0;
      exp_q.delete();
      last_d = '0;
      rst_seen = 1;
    end else begin
      if (g) begin
        p = int'(pos_bus[ref_slot*AW +: AW]);
        a = (ref_base[ref_slot] + p) % DEPTH;
        exp_q.push_back(ref_mem[a]);
        pend = 1;
        ref_slot = (ref_slot + 1) % N;
      end
      if (base_we && int'(base_sel) < N) ref_base[base_sel] = int'(base_addr);
    end
    if (wr_en) ref_mem[wr_addr] = wr_data;
  end

  task automatic wait_grant(input int k, input logic [W-1:0] exp, input string nm);
    bit found = 0;
    for (int i = 0; i < 2*N && !found; i++) begin
      @(negedge pixel_clock);
      if (dma_avail[k]) begin
        found = 1;
        step();
        @(negedge pixel_clock);
        chk(nm, data, exp);
      end
      step();
    end
    chk({nm, "_seen"}, found, 1);
  endtask

  logic [W-1:0] rot_exp [4] = '{8'hA6, 8'hB6, 8'h86, 8'h96};

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 0; dma_window = 1; base_we = 0; base_sel = '0; base_addr = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; pos_bus = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pixel_clock);
      chk("rst_avail", dma_avail, 0);
      if (i > 0) chk("rst_data", data, 0);
    end
    step();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1; wr_addr = MAW'(i); wr_data = W'(i) ^ 8'hA5;
      step();
    end
    wr_en = 0;
    @(negedge pixel_clock);
    chk("rst_avail_win", dma_avail, 0);
    step();
    reset_n = 1;
    @(negedge pixel_clock);
    chk("first_grant", dma_avail, 4'b0001);
    step();
    reset_n = 0; dma_window = 0;
    step();
    reset_n = 1;
    @(negedge pixel_clock);
    chk("rst_discard", data, 0);

    for (int k = 0; k < N; k++) begin
      base_we = 1; base_sel = SW'(k); base_addr = MAW'(16*k);
      step();
    end
    base_we = 0;
    for (int k = 0; k < N; k++) pos_bus[k*AW +: AW] = 9'd3;
    step();

    dma_window = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge pixel_clock);
      chk("rot_grant", dma_avail, 32'd1 << (i % 4));
      if (i > 0) chk("rot_data", data, rot_exp[(i-1) % 4]);
      step();
    end
    step();
    wr_en = 1; wr_addr = 11'd19; wr_data = 8'h3C;
    @(negedge pixel_clock);
    chk("wp_none", dma_avail, 0);
    step();
    wr_en = 0;
    @(negedge pixel_clock);
    chk("wp_grant", dma_avail, 4'b0010);
    step();
    @(negedge pixel_clock);
    chk("wp_data", data, 8'h3C);
    step();

    dma_window = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge pixel_clock);
      chk("closed_avail", dma_avail, 0);
      chk("closed_data", data, 8'h86);
      step();
    end
    dma_window = 1;
    @(negedge pixel_clock);
    chk("reopen", dma_avail, 4'b1000);
    step();

    dma_window = 0; base_we = 1; base_sel = 2'd2; base_addr = 11'd2040;
    wr_en = 1; wr_addr = 11'd2; wr_data = 8'h5A; pos_bus[2*AW +: AW] = 9'd10;
    step();
    base_we = 0; wr_en = 0; dma_window = 1;
    wait_grant(2, 8'h5A, "wrap");

    for (int i = 0; i < 2*N; i++) begin
      @(negedge pixel_clock);
      if (dma_avail[N-1]) break;
      step();
    end
    step();
    base_we = 1; base_sel = 2'd0; base_addr = 11'd100;
    @(negedge pixel_clock);
    chk("coll_grant", dma_avail, 4'b0001);
    step();
    base_we = 0;
    @(negedge pixel_clock);
    chk("coll_old", data, 8'hA6);
    wait_grant(0, 8'hC2, "coll_new");

    for (int i = 0; i < 500; i++) begin
      reset_n    = ($urandom_range(0, 39) != 0);
      dma_window = ($urandom_range(0, 3) != 0);
      wr_en      = ($urandom_range(0, 7) == 0);
      wr_addr    = MAW'($urandom());
      wr_data    = W'($urandom());
      base_we    = ($urandom_range(0, 7) == 0);
      base_sel   = SW'($urandom());
      base_addr  = MAW'($urandom());
      pos_bus    = (N*AW)'({$urandom(), $urandom()});
      step();
    end
    reset_n = 1; dma_window = 0; wr_en = 0; base_we = 0;
    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
